// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl:
// decode/EX hazard inputs in one direction, stage control and counters back.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_re;
  logic [4:0]  ex_rd;
  logic        ex_br_valid;
  logic        ex_br_taken;
  logic        ex_pred;
  logic        mem_busy;
  logic        clear_counts;
  logic        hold_pc;
  logic        hold_ifid;
  logic        stall_idex;
  logic        freeze;
  logic        flush_ifid;
  logic        flush_idex;
  logic        redirect;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_re, ex_rd,
    output ex_br_valid, ex_br_taken, ex_pred, mem_busy, clear_counts,
    input  hold_pc, hold_ifid, stall_idex, freeze, flush_ifid, flush_idex, redirect,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_re, ex_rd,
    input  ex_br_valid, ex_br_taken, ex_pred, mem_busy, clear_counts,
    output hold_pc, hold_ifid, stall_idex, freeze, flush_ifid, flush_idex, redirect,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze and branch
// mispredict flush, with saturating stall/flush event counters.
module pipe_hazard_ctrl (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOADUSE = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;
  logic        w_mp;
  logic        w_lu;
  logic        w_hold_pc;
  logic        w_hold_ifid;
  logic        w_stall_idex;
  logic        w_freeze;
  logic        w_flush_ifid;
  logic        w_flush_idex;
  logic        w_redirect;

  assign w_mp = bus.ex_br_valid & (bus.ex_br_taken != bus.ex_pred);
  assign w_lu = bus.ex_re & (bus.ex_rd != 5'd0) &
                ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and stage controls; everything is forced low while reset is held
  always_comb begin
    w_next       = r_state;
    w_hold_pc    = 1'b0;
    w_hold_ifid  = 1'b0;
    w_stall_idex = 1'b0;
    w_freeze     = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_redirect   = 1'b0;
    if (reset) begin
      w_next = RUN;
    end else begin
      case (r_state)
        RUN, LOADUSE: begin
          if (w_mp) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
            w_redirect   = 1'b1;
            w_next       = FLUSH;
          end else if (bus.mem_busy) begin
            w_freeze    = 1'b1;
            w_hold_pc   = 1'b1;
            w_hold_ifid = 1'b1;
            w_next      = MEMWAIT;
          end else if (w_lu && (r_state == RUN)) begin
            w_hold_pc    = 1'b1;
            w_hold_ifid  = 1'b1;
            w_stall_idex = 1'b1;
            w_next       = LOADUSE;
          end else begin
            w_next = RUN;
          end
        end
        // EX is frozen while memory is busy, so a pending mispredict waits
        MEMWAIT: begin
          if (bus.mem_busy) begin
            w_freeze    = 1'b1;
            w_hold_pc   = 1'b1;
            w_hold_ifid = 1'b1;
            w_next      = MEMWAIT;
          end else if (w_mp) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
            w_redirect   = 1'b1;
            w_next       = FLUSH;
          end else begin
            w_next = RUN;
          end
        end
        FLUSH: begin
          w_flush_ifid = 1'b1;
          w_next       = RUN;
        end
        default: begin
          w_next = RUN;
        end
      endcase
    end
  end

  // Saturating event counters; clear wins over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else if (bus.clear_counts) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if ((w_stall_idex | w_freeze) && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_redirect && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign bus.hold_pc     = w_hold_pc;
  assign bus.hold_ifid   = w_hold_ifid;
  assign bus.stall_idex  = w_stall_idex;
  assign bus.freeze      = w_freeze;
  assign bus.flush_ifid  = w_flush_ifid;
  assign bus.flush_idex  = w_flush_idex;
  assign bus.redirect    = w_redirect;
  assign bus.state       = r_state;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against an event-flag model.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: remembers which event the previous cycle produced
  bit m_flush_pend = 1'b0;
  bit m_memwait    = 1'b0;
  bit m_after_lu   = 1'b0;
  int m_stall      = 0;
  int m_flush      = 0;

  // Returns {hold_pc, hold_ifid, stall_idex, freeze, flush_ifid, flush_idex, redirect}
  function automatic logic [6:0] model_ctl();
    logic mp, lu;
    mp = bus.ex_br_valid && (bus.ex_br_taken != bus.ex_pred);
    lu = bus.ex_re && (bus.ex_rd != 5'd0) &&
         ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
    if (reset)                         return 7'b0000000;
    if (m_flush_pend)                  return 7'b0000100;
    if (m_memwait && bus.mem_busy)     return 7'b1101000;
    if (mp)                            return 7'b0000111;
    if (m_memwait)                     return 7'b0000000;
    if (bus.mem_busy)                  return 7'b1101000;
    if (lu && !m_after_lu)             return 7'b1110000;
    return 7'b0000000;
  endfunction

  function automatic int model_state();
    if (m_flush_pend) return 3;
    if (m_memwait)    return 2;
    if (m_after_lu)   return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on each clock edge; reset clears it at once
  always @(posedge clock or posedge reset) begin
    logic [6:0] c;
    if (reset) begin
      m_flush_pend = 1'b0;
      m_memwait    = 1'b0;
      m_after_lu   = 1'b0;
      m_stall      = 0;
      m_flush      = 0;
    end else begin
      c = model_ctl();
      if (bus.clear_counts) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if ((c[4] || c[3]) && m_stall < 65535) m_stall++;
        if (c[0] && m_flush < 65535)           m_flush++;
      end
      m_flush_pend = c[0];
      m_memwait    = c[3];
      m_after_lu   = c[4];
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clock) begin
    logic [6:0] c;
    c = model_ctl();
    chk("hold_pc",     32'(bus.hold_pc),    32'(c[6]));
    chk("hold_ifid",   32'(bus.hold_ifid),  32'(c[5]));
    chk("stall_idex",  32'(bus.stall_idex), 32'(c[4]));
    chk("freeze",      32'(bus.freeze),     32'(c[3]));
    chk("flush_ifid",  32'(bus.flush_ifid), 32'(c[2]));
    chk("flush_idex",  32'(bus.flush_idex), 32'(c[1]));
    chk("redirect",    32'(bus.redirect),   32'(c[0]));
    chk("state",       32'(bus.state),      32'(model_state()));
    chk("stall_count", 32'(bus.stall_count), 32'(m_stall));
    chk("flush_count", 32'(bus.flush_count), 32'(m_flush));
    chk("stall_x_freeze", 32'(bus.stall_idex & bus.freeze), 32'd0);
    chk("flush_x_freeze", 32'((bus.flush_ifid | bus.flush_idex) & bus.freeze), 32'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.id_uses_rt   = 1'b0;
    bus.ex_re        = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.ex_br_valid  = 1'b0;
    bus.ex_br_taken  = 1'b0;
    bus.ex_pred      = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.clear_counts = 1'b0;
  endtask

  initial begin
    idle_in();
    tick();
    tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_count), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Load-use on rs
    bus.ex_re = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    #3;
    chk("lu_stall", 32'(bus.stall_idex), 32'd1);
    chk("lu_hold_pc", 32'(bus.hold_pc), 32'd1);
    tick();
    idle_in();
    #3;
    chk("lu_state", 32'(bus.state), 32'd1);
    chk("lu_no_stall", 32'(bus.stall_idex), 32'd0);
    tick();
    #3;
    chk("lu_back_run", 32'(bus.state), 32'd0);
    chk("lu_count", 32'(bus.stall_count), 32'd1);

    // Non-hazards: rd=0, and rt match without rt use
    bus.ex_re = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0;
    #3;
    chk("rd0_no_stall", 32'(bus.stall_idex), 32'd0);
    tick();
    bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3; bus.id_uses_rt = 1'b0;
    #3;
    chk("rt_unused_no_stall", 32'(bus.stall_idex), 32'd0);
    tick();
    bus.id_uses_rt = 1'b1;
    #3;
    chk("rt_used_stall", 32'(bus.stall_idex), 32'd1);
    tick();
    idle_in();
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    #3;
    chk("clear_count", 32'(bus.stall_count), 32'd0);
    tick();

    // Memory wait: entry cycle plus three busy cycles in MEMWAIT
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("mw_freeze", 32'(bus.freeze), 32'd1);
      tick();
    end
    bus.mem_busy = 1'b0;
    #3;
    chk("mw_release", 32'(bus.freeze), 32'd0);
    chk("mw_rel_state", 32'(bus.state), 32'd2);
    tick();
    #3;
    chk("mw_run", 32'(bus.state), 32'd0);
    chk("mw_count", 32'(bus.stall_count), 32'd4);
    tick();

    // Mispredict beats mem_busy and load-use
    bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_pred = 1'b0;
    bus.mem_busy = 1'b1; bus.ex_re = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    #3;
    chk("mp_ctl", 32'({bus.flush_ifid, bus.flush_idex, bus.redirect, bus.freeze, bus.stall_idex}),
        32'b11100);
    tick();
    bus.mem_busy = 1'b0; bus.ex_re = 1'b0;
    #3;
    chk("fl_state", 32'(bus.state), 32'd3);
    chk("fl_ctl", 32'({bus.flush_ifid, bus.flush_idex, bus.redirect}), 32'b100);
    tick();
    idle_in();
    #3;
    chk("fl_run", 32'(bus.state), 32'd0);
    chk("fl_count", 32'(bus.flush_count), 32'd1);
    tick();

    // Mispredict waits out MEMWAIT, then fires when memory is ready
    bus.mem_busy = 1'b1;
    tick();
    bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b0; bus.ex_pred = 1'b1;
    #3;
    chk("mw_mp_ignored", 32'(bus.redirect), 32'd0);
    tick();
    bus.mem_busy = 1'b0;
    #3;
    chk("mw_mp_fire", 32'({bus.flush_idex, bus.redirect}), 32'b11);
    tick();
    idle_in();
    tick();
    tick();

    // Long freeze saturates the stall counter
    bus.mem_busy = 1'b1;
    repeat (65540) tick();
    #3;
    chk("sat_stall", 32'(bus.stall_count), 32'hFFFF);
    tick();
    bus.mem_busy = 1'b0;
    #3;
    chk("sat_hold", 32'(bus.stall_count), 32'hFFFF);
    tick();
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    #3;
    chk("sat_clear_stall", 32'(bus.stall_count), 32'd0);
    chk("sat_clear_flush", 32'(bus.flush_count), 32'd0);
    tick();

    // Reset abandons MEMWAIT asynchronously
    bus.mem_busy = 1'b1;
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_freeze", 32'(bus.freeze), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_count", 32'(bus.stall_count), 32'd0);
    bus.mem_busy = 1'b0;
    tick();
    reset = 1'b0;
    #3;
    chk("post_rst_state", 32'(bus.state), 32'd0);
    chk("post_rst_ctl", 32'({bus.hold_pc, bus.freeze, bus.flush_ifid}), 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
